multicycle_control_fsm: RTL and testbench

//  Next-generation multicycle control unit for the datapath. Decodes a parametrised-width opcode.

---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/mem_wait_watchdog.sv | 37 +++
 rtl/multicycle_control_fsm.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes and datapath select codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_LW1    = 4'd3,
        S_LW2    = 4'd4,
        S_SW1    = 4'd5,
        S_REXEC  = 4'd6,
        S_RWRITE = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_AEXEC  = 4'd10,
        S_AWRITE = 4'd11,
        S_OUTW   = 4'd12,
        S_ERROR  = 4'd13
    } state_e;

    // Opcode values, zero-extended to the configured opcode width at the point of use.
    localparam int OP_R    = 0;
    localparam int OP_J    = 2;
    localparam int OP_LW   = 3;
    localparam int OP_BEQ  = 4;
    localparam int OP_BNE  = 5;
    localparam int OP_ADDI = 8;
    localparam int OP_SW   = 11;
    localparam int OP_OUT  = 15;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_REGB  = 2'd0;
    localparam logic [1:0] SRCB_CONST = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_SHIMM = 2'd3;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_IMM    = 2'd2;

    // States that wait on MemReady and are therefore covered by the watchdog.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_LW1) || (s == S_SW1);
    endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts consecutive MemReady-low cycles while the FSM sits in a memory state and flags expiry.
module mem_wait_watchdog #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    input  logic mem_ready_i,
    output logic expire_o
);

    localparam bit ENABLED = (WAIT_MAX > 0);
    localparam int CW      = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] LAST = CW'((WAIT_MAX > 0) ? (WAIT_MAX - 1) : 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Leaving a memory state clears the count, so every entry starts from zero.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!ENABLED || !active_i || mem_ready_i) begin
            cnt_d = '0;
        end
    end

    assign expire_o = ENABLED && active_i && !mem_ready_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle datapath controller: one Moore FSM drives all selects and enables, with a memory
// watchdog, sticky error state and a retired-instruction counter.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int WAIT_MAX = 15,
    parameter int ICNT_W   = 16
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                MemReady,
    output logic [1:0]          ALUOp,
    output logic                SrcA,
    output logic [1:0]          SrcB,
    output logic [1:0]          MemtoReg,
    output logic                RegDest,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic [1:0]          PCSrc,
    output logic                MemSrc,
    output logic                OutputWrite,
    output logic                BranchCond,
    output logic                InstrDone,
    output logic [ICNT_W-1:0]   InstrCount,
    output logic                Error,
    output logic [3:0]          current_state
);

    state_e              state_q;
    state_e              state_d;
    logic [OPCODE_W-1:0] opcode_q;
    logic [ICNT_W-1:0]   icnt_q;
    logic                wd_expire;

    function automatic logic op_is(input logic [OPCODE_W-1:0] op, input int code);
        return op == OPCODE_W'(code);
    endfunction

    mem_wait_watchdog #(
        .WAIT_MAX(WAIT_MAX)
    ) u_watchdog (
        .clk_i      (CLK),
        .rst_ni     (Reset),
        .active_i   (is_mem_state(state_q)),
        .mem_ready_i(MemReady),
        .expire_o   (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (wd_expire)     state_d = S_ERROR;
                else if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (op_is(Opcode, OP_R))                                state_d = S_REXEC;
                else if (op_is(Opcode, OP_J))                           state_d = S_JUMP;
                else if (op_is(Opcode, OP_LW) || op_is(Opcode, OP_SW))  state_d = S_MEMADR;
                else if (op_is(Opcode, OP_BEQ) || op_is(Opcode, OP_BNE)) state_d = S_BRANCH;
                else if (op_is(Opcode, OP_ADDI))                        state_d = S_AEXEC;
                else if (op_is(Opcode, OP_OUT))                         state_d = S_OUTW;
                else                                                    state_d = S_ERROR;
            end
            S_MEMADR: state_d = op_is(opcode_q, OP_LW) ? S_LW1 : S_SW1;
            S_LW1: begin
                if (wd_expire)     state_d = S_ERROR;
                else if (MemReady) state_d = S_LW2;
            end
            S_SW1: begin
                if (wd_expire)     state_d = S_ERROR;
                else if (MemReady) state_d = S_FETCH;
            end
            S_REXEC:  state_d = S_RWRITE;
            S_AEXEC:  state_d = S_AWRITE;
            S_LW2, S_RWRITE, S_BRANCH, S_JUMP, S_AWRITE, S_OUTW: state_d = S_FETCH;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase
    end

    // Everything is gated by Reset so an assertion mid-instruction silences the datapath at once.
    always_comb begin
        ALUOp       = ALU_ADD;
        SrcA        = 1'b0;
        SrcB        = SRCB_REGB;
        MemtoReg    = M2R_ALUOUT;
        RegDest     = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        PCSrc       = PCSRC_ALU;
        MemSrc      = 1'b0;
        OutputWrite = 1'b0;
        BranchCond  = 1'b0;
        InstrDone   = 1'b0;
        if (Reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    SrcB    = SRCB_CONST;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE: SrcB = SRCB_SHIMM;
                S_MEMADR, S_AEXEC: begin
                    SrcA = 1'b1;
                    SrcB = SRCB_IMM;
                end
                S_LW1: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_LW2: begin
                    RegWrite  = 1'b1;
                    MemtoReg  = M2R_MDR;
                    InstrDone = 1'b1;
                end
                S_SW1: begin
                    MemWrite  = MemReady;
                    IorD      = 1'b1;
                    InstrDone = MemReady;
                end
                S_REXEC: begin
                    SrcA  = 1'b1;
                    ALUOp = ALU_FUNCT;
                end
                S_RWRITE: begin
                    RegWrite  = 1'b1;
                    RegDest   = 1'b1;
                    InstrDone = 1'b1;
                end
                S_BRANCH: begin
                    SrcA        = 1'b1;
                    ALUOp       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSrc       = PCSRC_ALUOUT;
                    BranchCond  = op_is(opcode_q, OP_BNE);
                    InstrDone   = 1'b1;
                end
                S_JUMP: begin
                    PCWrite   = 1'b1;
                    PCSrc     = PCSRC_JUMP;
                    InstrDone = 1'b1;
                end
                S_AWRITE: begin
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_OUTW: begin
                    OutputWrite = 1'b1;
                    InstrDone   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            icnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= Opcode;
            end
            if (InstrDone) begin
                icnt_q <= icnt_q + 1'b1;
            end
        end
    end

    // ERROR is terminal until Reset, so the sticky flag is simply the state itself.
    assign Error         = (state_q == S_ERROR);
    assign InstrCount    = icnt_q;
    assign current_state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized instruction stream against a per-instruction activity model, plus directed reset,
// illegal-opcode and watchdog scenarios.
module tb_multicycle_control_fsm;
    import ctrl_pkg::*;

    localparam int OPCODE_W = 4;
    localparam int WAIT_MAX = 15;
    localparam int ICNT_W   = 16;

    logic                CLK = 1'b0;
    logic                Reset;
    logic [OPCODE_W-1:0] Opcode;
    logic                MemReady;
    logic [1:0]          ALUOp;
    logic                SrcA;
    logic [1:0]          SrcB;
    logic [1:0]          MemtoReg;
    logic                RegDest;
    logic                RegWrite;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic                PCWrite;
    logic                PCWriteCond;
    logic                IorD;
    logic [1:0]          PCSrc;
    logic                MemSrc;
    logic                OutputWrite;
    logic                BranchCond;
    logic                InstrDone;
    logic [ICNT_W-1:0]   InstrCount;
    logic                Error;
    logic [3:0]          current_state;

    always #5 CLK = ~CLK;

    multicycle_control_fsm #(
        .OPCODE_W(OPCODE_W),
        .WAIT_MAX(WAIT_MAX),
        .ICNT_W  (ICNT_W)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Opcode       (Opcode),
        .MemReady     (MemReady),
        .ALUOp        (ALUOp),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .MemtoReg     (MemtoReg),
        .RegDest      (RegDest),
        .RegWrite     (RegWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .PCWriteCond  (PCWriteCond),
        .IorD         (IorD),
        .PCSrc        (PCSrc),
        .MemSrc       (MemSrc),
        .OutputWrite  (OutputWrite),
        .BranchCond   (BranchCond),
        .InstrDone    (InstrDone),
        .InstrCount   (InstrCount),
        .Error        (Error),
        .current_state(current_state)
    );

    logic [7:0]  en_vec;
    logic [12:0] sel_vec;
    assign en_vec  = {RegWrite, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, OutputWrite, InstrDone};
    assign sel_vec = {ALUOp, SrcA, SrcB, MemtoReg, RegDest, IorD, PCSrc, MemSrc, BranchCond};

    // Per-instruction activity: cycle count plus the sum of every control output over its cycles.
    typedef struct packed {
        logic [7:0]  cyc;
        logic [7:0]  mr;
        logic [7:0]  iord;
        logic [7:0]  srcb;
        logic [2:0]  rw;
        logic [2:0]  m2r;
        logic [2:0]  rdst;
        logic [2:0]  mw;
        logic [2:0]  pcw;
        logic [2:0]  irw;
        logic [2:0]  pcwc;
        logic [2:0]  bc;
        logic [2:0]  ow;
        logic [2:0]  memsrc;
        logic [3:0]  alu;
        logic [3:0]  srca;
        logic [3:0]  pcsrc;
        logic [15:0] icnt;
    } sig_t;
    localparam int SIG_W = $bits(sig_t);

    logic [SIG_W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int model_icnt = 0;
    int legal_ops [0:7] = '{OP_R, OP_J, OP_LW, OP_BEQ, OP_BNE, OP_ADDI, OP_SW, OP_OUT};
    int illegal_ops [0:6] = '{1, 6, 7, 9, 10, 12, 13};
    sig_t acc;
    logic [SIG_W-1:0] exp_w;

    // f = MemReady-low cycles in fetch, m = MemReady-low cycles in the load/store access.
    function automatic sig_t model_sig(input int op, input int f, input int m, input int icnt);
        sig_t s;
        s      = '0;
        s.cyc  = 8'(f + 3);
        s.mr   = 8'(f + 1);
        s.srcb = 8'(f + 1 + 3);
        s.irw  = 3'd1;
        s.pcw  = 3'd1;
        s.icnt = 16'(icnt);
        case (op)
            OP_R: begin
                s.cyc = 8'(f + 4); s.rw = 3'd1; s.rdst = 3'd1; s.alu = 4'd2; s.srca = 4'd1;
            end
            OP_ADDI: begin
                s.cyc = 8'(f + 4); s.rw = 3'd1; s.srca = 4'd1; s.srcb = s.srcb + 8'd2;
            end
            OP_J: begin
                s.pcw = 3'd2; s.pcsrc = 4'd2;
            end
            OP_BEQ, OP_BNE: begin
                s.pcwc = 3'd1; s.bc = (op == OP_BNE) ? 3'd1 : 3'd0;
                s.alu = 4'd1; s.srca = 4'd1; s.pcsrc = 4'd1;
            end
            OP_OUT: s.ow = 3'd1;
            OP_LW: begin
                s.cyc = 8'(f + m + 5); s.mr = 8'(f + m + 2); s.iord = 8'(m + 1);
                s.rw = 3'd1; s.m2r = 3'd1; s.srca = 4'd1; s.srcb = s.srcb + 8'd2;
            end
            OP_SW: begin
                s.cyc = 8'(f + m + 4); s.mw = 3'd1; s.iord = 8'(m + 1);
                s.srca = 4'd1; s.srcb = s.srcb + 8'd2;
            end
            default: ;
        endcase
        return s;
    endfunction

    // Monitor: accumulate activity and compare against the scoreboard at each InstrDone.
    always @(negedge CLK) begin
        if (!Reset) begin
            acc = '0;
        end else begin
            acc.cyc    = acc.cyc + 8'd1;
            acc.mr     = acc.mr + 8'(MemRead);
            acc.iord   = acc.iord + 8'(IorD);
            acc.srcb   = acc.srcb + 8'(SrcB);
            acc.rw     = acc.rw + 3'(RegWrite);
            acc.m2r    = acc.m2r + 3'(MemtoReg);
            acc.rdst   = acc.rdst + 3'(RegDest);
            acc.mw     = acc.mw + 3'(MemWrite);
            acc.pcw    = acc.pcw + 3'(PCWrite);
            acc.irw    = acc.irw + 3'(IRWrite);
            acc.pcwc   = acc.pcwc + 3'(PCWriteCond);
            acc.bc     = acc.bc + 3'(BranchCond);
            acc.ow     = acc.ow + 3'(OutputWrite);
            acc.memsrc = acc.memsrc + 3'(MemSrc);
            acc.alu    = acc.alu + 4'(ALUOp);
            acc.srca   = acc.srca + 4'(SrcA);
            acc.pcsrc  = acc.pcsrc + 4'(PCSrc);
            if (InstrDone) begin
                acc.icnt = InstrCount;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: InstrDone with empty queue, got %h", acc);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (exp_w != acc) begin
                        bad++;
                        $display("FAIL sb_instr: got %h expected %h", acc, exp_w);
                    end
                end
                acc = '0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic step(input logic mr);
        MemReady = mr;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_instr(input int op, input int f, input int m);
        sig_t s;
        s = model_sig(op, f, m, model_icnt);
        exp_q.push_back(s);
        model_icnt++;
        Opcode = OPCODE_W'(op);
        repeat (f) step(1'b0);
        step(1'b1);
        step(1'($urandom_range(0, 1)));
        Opcode = OPCODE_W'($urandom_range(0, 15));
        case (op)
            OP_R, OP_ADDI: repeat (2) step(1'($urandom_range(0, 1)));
            OP_LW: begin
                step(1'($urandom_range(0, 1)));
                repeat (m) step(1'b0);
                step(1'b1);
                step(1'($urandom_range(0, 1)));
            end
            OP_SW: begin
                step(1'($urandom_range(0, 1)));
                repeat (m) step(1'b0);
                step(1'b1);
            end
            default: step(1'($urandom_range(0, 1)));
        endcase
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        model_icnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        Reset    = 1'b0;
        Opcode   = '0;
        MemReady = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        MemReady = 1'b1;
        @(negedge CLK);
        chk("reset_state", 32'(current_state), 32'(S_FETCH));
        chk("reset_enables", 32'(en_vec), 32'd0);
        chk("reset_selects", 32'(sel_vec), 32'd0);
        chk("reset_icnt", 32'(InstrCount), 32'd0);
        chk("reset_error", 32'(Error), 32'd0);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        model_icnt = 0;

        run_instr(OP_R, 0, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_BNE, 1, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_SW, 2, 14);
        run_instr(OP_LW, 14, 14);
        for (int i = 0; i < 40; i++) begin
            run_instr(legal_ops[$urandom_range(0, 7)],
                      ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 4)),
                      ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 4)));
        end
        MemReady = 1'b0;
        @(negedge CLK);
        chk("icnt_after_run", 32'(InstrCount), 32'(16'(model_icnt)));
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        @(posedge CLK);
        #1;

        Opcode = OPCODE_W'(OP_LW);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        chk("lw1_memread_pre", 32'({MemRead, IorD}), 32'b11);
        Reset = 1'b0;
        #1;
        chk("abort_state", 32'(current_state), 32'(S_FETCH));
        chk("abort_enables", 32'(en_vec), 32'd0);
        chk("abort_icnt", 32'(InstrCount), 32'd0);
        @(negedge CLK);
        chk("abort_next_memread", 32'(MemRead), 32'd0);
        chk("abort_next_error", 32'(Error), 32'd0);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        model_icnt = 0;
        run_instr(OP_ADDI, 0, 0);
        run_instr(OP_OUT, 1, 0);

        Opcode = 4'd7;
        step(1'b1);
        step(1'b0);
        for (int i = 0; i < 4; i++) begin
            Opcode   = OPCODE_W'($urandom_range(0, 15));
            MemReady = 1'($urandom_range(0, 1));
            @(negedge CLK);
            chk("illegal_error", 32'(Error), 32'd1);
            chk("illegal_state", 32'(current_state), 32'(S_ERROR));
            chk("illegal_enables", 32'(en_vec), 32'd0);
            @(posedge CLK);
            #1;
        end
        do_reset();
        Opcode = OPCODE_W'(illegal_ops[$urandom_range(0, 6)]);
        step(1'b1);
        step(1'b1);
        @(negedge CLK);
        chk("illegal2_error", 32'(Error), 32'd1);
        chk("illegal2_selects", 32'(sel_vec), 32'd0);
        @(posedge CLK);
        #1;

        do_reset();
        Opcode = '0;
        for (int i = 1; i <= 15; i++) begin
            MemReady = 1'b0;
            @(negedge CLK);
            if (i == 1 || i == 14 || i == 15) begin
                chk("wd_wait_error", 32'(Error), 32'd0);
                chk("wd_wait_state", 32'(current_state), 32'(S_FETCH));
            end
            @(posedge CLK);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            MemReady = 1'b1;
            @(negedge CLK);
            chk("wd_sticky_error", 32'(Error), 32'd1);
            chk("wd_sticky_enables", 32'(en_vec), 32'd0);
            @(posedge CLK);
            #1;
        end
        Reset = 1'b0;
        #1;
        chk("wd_cleared_by_reset", 32'(Error), 32'd0);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        model_icnt = 0;
        run_instr(OP_J, 0, 0);
        chk("sb_final_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
